// File: rtl/abft_retry_controller_pkg.sv
// abft_ctrl_pkg: shared state encoding, width helpers and priority-pick function
package abft_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, SETTLE, CHECK, REPORT, REARM, FATAL} ctrl_state_t;
  localparam int MAX_ERR_W = 96;
  function automatic int err_w(int n);
    return 6 * n;
  endfunction
  function automatic int idx_w(int n);
    return $clog2(6 * n);
  endfunction
  function automatic int lowest_set_idx(logic [MAX_ERR_W-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_ERR_W - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/abft_retry_controller_if.sv
// abft_retry_controller_if: command, array/detector and error-report signals of the retry controller
interface abft_retry_controller_if import abft_ctrl_pkg::*; #(parameter int arraySize = 4);
  logic start, abort, job_done, array_start, det_rst, rpt_valid, rpt_ready, busy, done, fatal;
  logic [err_w(arraySize)-1:0] error;
  logic [idx_w(arraySize)-1:0] rpt_idx;
  logic [3:0] rpt_attempt, retry_count;
  modport master (
    input start, abort, job_done, error, rpt_ready,
    output array_start, det_rst, rpt_valid, rpt_idx, rpt_attempt, busy, done, fatal, retry_count
  );
  modport slave (
    output start, abort, job_done, error, rpt_ready,
    input array_start, det_rst, rpt_valid, rpt_idx, rpt_attempt, busy, done, fatal, retry_count
  );
endinterface

// File: rtl/abft_retry_controller_dff.sv
// dff: register cell with synchronous active-low reset to a parameterised value
module dff #(
  parameter int W = 1,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // reset wins at the edge, otherwise capture d
  always_ff @(posedge clk) q <= !rst ? RV : d;
endmodule

// File: rtl/abft_retry_controller_lsb_priority_encoder.sv
// lsb_priority_encoder: index of the lowest set bit plus an any-set flag
module lsb_priority_encoder import abft_ctrl_pkg::*; #(
  parameter int ERR_W = 24,
  parameter int IDX_W = 5
) (
  input  logic [ERR_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);
  assign hit = |vec;
  assign idx = IDX_W'(lowest_set_idx(MAX_ERR_W'(vec)));
endmodule

// File: rtl/abft_retry_controller.sv
// abft_retry_controller: runs an ABFT array job, reports detected error bits and restarts up to MAX_RETRIES times
module abft_retry_controller import abft_ctrl_pkg::*; #(
  parameter int arraySize = 4,
  parameter int MAX_RETRIES = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  abft_retry_controller_if.master bus
);
  localparam int ERR_W = err_w(arraySize);
  localparam int IDX_W = idx_w(arraySize);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = 3 + ERR_W + 4 + CW + 3;
  logic [2:0] st, st_d;
  logic [ERR_W-1:0] snap, snap_d, snap_rest;
  logic [3:0] rc, rc_d;
  logic [CW-1:0] cnt, cnt_d;
  logic as_q, as_d, dr_q, dr_d, dn_q, dn_d, hit, busy_w;
  logic [IDX_W-1:0] idx;
  lsb_priority_encoder #(.ERR_W(ERR_W), .IDX_W(IDX_W)) u_enc (.vec(snap), .idx(idx), .hit(hit));
  dff #(.W(RW), .RV({IDLE, {(ERR_W + 4 + CW + 1){1'b0}}, 1'b1, 1'b0})) u_regs (
    .clk(clk),
    .rst(rst),
    .d({st_d, snap_d, rc_d, cnt_d, as_d, dr_d, dn_d}),
    .q({st, snap, rc, cnt, as_q, dr_q, dn_q})
  );
  assign busy_w = st != IDLE && st != FATAL;
  assign snap_rest = snap & (snap - ERR_W'(1));
  // next-state: abort overrides everything; a report handshake retires the lowest pending bit
  always_comb begin
    st_d = st;
    snap_d = snap;
    rc_d = rc;
    cnt_d = cnt;
    as_d = 1'b0;
    dr_d = 1'b1;
    dn_d = 1'b0;
    if (bus.abort) begin
      if (st != IDLE) begin
        st_d = IDLE;
        snap_d = '0;
        rc_d = '0;
        dr_d = st == FATAL;
      end
    end else begin
      case (st)
        IDLE, FATAL: if (bus.start) begin
          st_d = RUN;
          rc_d = '0;
          as_d = 1'b1;
        end
        RUN: if (bus.job_done) begin
          st_d = SETTLE;
          cnt_d = CW'(SETTLE_CYCLES);
        end
        SETTLE: begin
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            snap_d = bus.error;
            st_d = CHECK;
          end
        end
        CHECK: begin
          st_d = hit ? REPORT : IDLE;
          dn_d = !hit;
        end
        REPORT: if (bus.rpt_ready) begin
          snap_d = snap_rest;
          if (snap_rest == '0) st_d = rc == 4'(MAX_RETRIES) ? FATAL : REARM;
        end
        REARM: begin
          rc_d = rc + 4'd1;
          as_d = 1'b1;
          st_d = RUN;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  assign bus.array_start = as_q;
  assign bus.det_rst = dr_q && st != REARM;
  assign bus.rpt_valid = st == REPORT;
  assign bus.rpt_idx = idx;
  assign bus.rpt_attempt = rc;
  assign bus.busy = busy_w;
  assign bus.done = dn_q;
  assign bus.fatal = st == FATAL;
  assign bus.retry_count = rc;
endmodule

// File: tb/tb_abft_retry_controller.sv
// tb_abft_retry_controller: randomized jobs checked against a transaction-level retry/report model
module tb_abft_retry_controller;
  localparam int S = 2;
  localparam int MR = 3;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  abft_retry_controller_if #(.arraySize(4)) bus ();
  abft_retry_controller #(.arraySize(4), .MAX_RETRIES(MR), .SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  int n_chk = 0, n_pass = 0;
  int as_cnt = 0, dr_cnt = 0, dn_cnt = 0;
  int mon_idx[$], mon_att[$];
  logic [23:0] errs[4];
  int rmode = 0;
  logic stall_q = 0;
  logic [8:0] held = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (stall_q && bus.rpt_valid) chk("rpt_hold", {23'd0, bus.rpt_idx, bus.rpt_attempt}, {23'd0, held});
    stall_q = bus.rpt_valid && !bus.rpt_ready && !bus.abort && rst;
    held = {bus.rpt_idx, bus.rpt_attempt};
    if (bus.rpt_valid && bus.rpt_ready) begin
      mon_idx.push_back(int'(bus.rpt_idx));
      mon_att.push_back(int'(bus.rpt_attempt));
    end
    as_cnt += int'(bus.array_start);
    dr_cnt += int'(!bus.det_rst);
    dn_cnt += int'(bus.done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_as"}, bus.array_start, 0);
    chk({tag, "_detrst"}, bus.det_rst, 1);
    chk({tag, "_valid"}, bus.rpt_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_fatal"}, bus.fatal, 0);
    chk({tag, "_rc"}, bus.retry_count, 0);
    chk({tag, "_idx"}, bus.rpt_idx, 0);
    chk({tag, "_att"}, bus.rpt_attempt, 0);
  endtask

  task automatic do_start();
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("start_pulse", bus.array_start, 1);
    chk("start_busy", bus.busy, 1);
    chk("start_fatal", bus.fatal, 0);
    chk("start_rc", bus.retry_count, 0);
  endtask

  task automatic launch(logic [23:0] e);
    int k, jl;
    k = $urandom_range(1, 10);
    jl = $urandom_range(1, S + 1);
    bus.error = e;
    repeat (k) begin
      bus.start = 1'($urandom_range(0, 1));
      tick();
    end
    bus.start = 0;
    for (int i = 0; i < S + 2; i++) begin
      bus.job_done = i < jl;
      tick();
      if (i == S) begin
        chk("early_done", bus.done, 0);
        chk("early_rpt", bus.rpt_valid, 0);
      end
    end
    bus.job_done = 0;
  endtask

  task automatic run_job();
    int a, as0, dr0, dn0;
    int exp_idx[$];
    logic [23:0] e;
    bit fin, fat;
    a = 0;
    fin = 0;
    fat = 0;
    as0 = as_cnt;
    dr0 = dr_cnt;
    dn0 = dn_cnt;
    do_start();
    while (!fin) begin
      e = errs[a];
      exp_idx.delete();
      for (int i = 0; i < 24; i++) if (e[i]) exp_idx.push_back(i);
      mon_idx.delete();
      mon_att.delete();
      launch(e);
      bus.error = 24'($urandom);
      if (e == 0) begin
        chk("done", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_rc", bus.retry_count, a);
        fin = 1;
      end else begin
        chk("rpt_valid", bus.rpt_valid, 1);
        for (int c = 0; c < 400 && mon_idx.size() < exp_idx.size(); c++) begin
          bus.rpt_ready = rmode != 0 ? (c >= 3 && c % 2 == 1) : 1'($urandom_range(0, 1));
          tick();
        end
        bus.rpt_ready = 0;
        chk("rpt_count", mon_idx.size(), exp_idx.size());
        foreach (exp_idx[j]) if (j < mon_idx.size()) begin
          chk("rpt_idx", mon_idx[j], exp_idx[j]);
          chk("rpt_att", mon_att[j], a);
        end
        chk("rpt_drop", bus.rpt_valid, 0);
        if (a == MR) begin
          chk("fatal", bus.fatal, 1);
          chk("fatal_busy", bus.busy, 0);
          fin = 1;
          fat = 1;
        end else begin
          chk("rearm_low", bus.det_rst, 0);
          tick();
          chk("rearm_high", bus.det_rst, 1);
          chk("restart", bus.array_start, 1);
          chk("retry_count", bus.retry_count, a + 1);
          a++;
        end
      end
    end
    tick();
    chk("pulses", as_cnt - as0, a + 1);
    chk("rearms", dr_cnt - dr0, a);
    chk("dones", dn_cnt - dn0, fat ? 0 : 1);
  endtask

  initial begin
    int p, d0;
    bus.start = 0;
    bus.abort = 0;
    bus.job_done = 0;
    bus.error = '0;
    bus.rpt_ready = 0;
    tick();
    tick();
    chk_reset("por");
    rst = 1;
    tick();
    errs = '{24'h0, 24'h0, 24'h0, 24'h0};
    run_job();
    errs = '{24'h000010, 24'h0, 24'h0, 24'h0};
    run_job();
    rmode = 1;
    errs = '{24'h800003, 24'h0, 24'h0, 24'h0};
    run_job();
    rmode = 0;
    errs = '{24'h000100, 24'h000100, 24'h000100, 24'h000100};
    run_job();
    repeat (12) begin
      p = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++)
        errs[i] = i < p ? (24'($urandom & $urandom) | (24'd1 << $urandom_range(0, 23))) : 24'h0;
      rmode = $urandom_range(0, 1);
      run_job();
    end
    rmode = 0;
    do_start();
    launch(24'h00000C);
    chk("ab_valid", bus.rpt_valid, 1);
    tick();
    tick();
    chk("ab_idx", bus.rpt_idx, 2);
    bus.rpt_ready = 1;
    bus.abort = 1;
    tick();
    bus.abort = 0;
    bus.rpt_ready = 0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_valid_off", bus.rpt_valid, 0);
    chk("ab_detrst", bus.det_rst, 0);
    chk("ab_rc", bus.retry_count, 0);
    chk("ab_snap", bus.rpt_idx, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("ab_detrst_back", bus.det_rst, 1);
    chk("ab_restart", bus.array_start, 1);
    chk("ab_rebusy", bus.busy, 1);
    launch(24'h0);
    chk("ab_done", bus.done, 1);
    tick();
    do_start();
    tick();
    tick();
    rst = 0;
    tick();
    rst = 1;
    chk_reset("mid");
    d0 = dn_cnt;
    bus.job_done = 1;
    tick();
    bus.job_done = 0;
    repeat (S + 4) tick();
    chk("rst_jd_busy", bus.busy, 0);
    chk("rst_jd_done", dn_cnt - d0, 0);
    chk("rst_jd_as", bus.array_start, 0);
    errs = '{24'h0, 24'h0, 24'h0, 24'h0};
    run_job();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/abft_retry_controller.md
Name: abft_retry_controller

Overview:
- Sequences one ABFT-protected array job and inspects the sticky 6*arraySize error vector from the memory error detector when the job finishes.
- If any error bit is set, serialises the set-bit indices to a report interface, re-arms the detector, and restarts the array.
- Gives up with a sticky fatal flag after MAX_RETRIES restarts.
- Sits between the system command interface and the array plus detector pair.

Parameters:
- arraySize, 4, array dimension; the error vector is 6*arraySize bits.
- MAX_RETRIES, 3, maximum restarts before fatal; must be 1..15.
- SETTLE_CYCLES, 2, cycles waited after job_done before sampling error; must be >=1; covers detector pipeline latency.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset; asserted when rst==0 at a clk edge
- start  in  1  begin a job; sampled only in IDLE or FATAL
- abort  in  1  cancel the current job, return to IDLE
- job_done  in  1  array has produced its final outputs; level, sampled in RUN only
- error  in  6*arraySize  detector sticky error vector
- array_start  out  1  one-cycle pulse starting an array pass
- det_rst  out  1  active-low re-arm of the detector; one-cycle low pulse
- rpt_valid  out  1  error report valid
- rpt_ready  in  1  report consumer ready
- rpt_idx  out  $clog2(6*arraySize)  bit index of the reported error
- rpt_attempt  out  4  attempt number (0 = first pass) of the reported error
- busy  out  1  high in every state except IDLE and FATAL
- done  out  1  one-cycle pulse: job completed with no errors
- fatal  out  1  sticky; retries exhausted
- retry_count  out  4  restarts issued for the current job

Behaviour:
- Reset values (rst==0):
  - All outputs 0, except det_rst=1.
  - State IDLE; snapshot register 0; retry_count 0.
- States and transitions:
  - IDLE: on start, pulse array_start, retry_count:=0, go to RUN.
  - RUN: on job_done, load settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the counter. When it reaches 0, sample error into the snapshot and go to CHECK.
  - CHECK:
    - snapshot==0: pulse done, go to IDLE.
    - otherwise: go to REPORT.
  - REPORT:
    - rpt_valid=1; rpt_idx = lowest set bit of the snapshot; rpt_attempt = retry_count.
    - On rpt_valid&&rpt_ready, clear that bit. Exactly one index is transferred per handshake.
    - When the last bit is transferred:
      - retry_count==MAX_RETRIES: go to FATAL.
      - otherwise: go to REARM.
    - rpt_idx and rpt_attempt hold stable while rpt_valid=1 and rpt_ready=0.
  - REARM: det_rst=0 for exactly one cycle, then retry_count++, pulse array_start, go to RUN.
  - FATAL: fatal=1 and busy=0. start clears fatal, retry_count:=0, pulses array_start, and goes to RUN.
- array_start latency: asserted in the cycle after start is sampled in IDLE or FATAL; asserted in the cycle after REARM.
- Start rules:
  - start while busy is ignored.
  - start and abort in the same IDLE cycle: abort wins; no job starts.
- Abort:
  - From any busy state, abort goes to IDLE at the next edge.
  - Drives det_rst=0 for one cycle and clears the snapshot, rpt_valid and retry_count.
  - In FATAL, abort clears fatal and goes to IDLE.
  - An abort in the same cycle as a report handshake takes precedence; the handshake is still counted by the consumer.
- job_done outside RUN is ignored.
- error changes outside the SETTLE sampling cycle are ignored; only the snapshot is used.
- rst mid-operation returns the block to the reset values in the next cycle; a partially transferred report is dropped.
- Widths: retry_count saturates by construction (bounded by MAX_RETRIES). The settle counter is $clog2(SETTLE_CYCLES+1) bits.

Decomposition:
- Package abft_ctrl_pkg holds:
  - enum ctrl_state_t {IDLE, RUN, SETTLE, CHECK, REPORT, REARM, FATAL}, 3 bits;
  - localparam ERR_W = 6*arraySize and IDX_W = $clog2(ERR_W), as parameterised functions;
  - function lowest_set_idx.
- One sub-module: lsb_priority_encoder.
  - Input: ERR_W-bit vector.
  - Outputs: IDX_W-bit index and any-set flag.
  - Purely combinational; used for rpt_idx.
- State and data registers use the team dff cell with the active-low synchronous reset.

Test Plan:
- Clean pass: start; job_done 10 cycles later; error=0 → done pulses exactly SETTLE_CYCLES+2 cycles after job_done; array_start pulsed once; busy falls with done; no rpt_valid.
- Single error then clean retry: error=24'h000010 on first pass → one report, rpt_idx=4, rpt_attempt=0; det_rst low one cycle; array_start again; retry_count=1; second pass clean → done.
- Multi-bit report with backpressure: error=24'h800003, rpt_ready low for 3 cycles then toggling → indices 0, 1, 23 in order; rpt_idx stable while stalled; exactly 3 handshakes.
- Retry exhaustion: MAX_RETRIES=3, every pass error=24'h000100 → 4 reports of idx 8 with attempts 0..3; fatal=1, busy=0; a further start clears fatal and restarts with retry_count=0.
- Abort in REPORT mid-stall: abort asserted while rpt_valid=1 → next cycle IDLE, rpt_valid=0, det_rst low one cycle, retry_count=0; a start in the following cycle starts a fresh job.
- Reset mid-RUN: rst=0 for one edge during RUN → all outputs at reset values; a job_done arriving afterwards is ignored; start required to run again.
